sum_n_param: RTL and testbench

Parametrised iterative series accumulator, successor to the fixed 3-bit `sum_N` block. Captures an operand N through a valid/ready handshake and computes the sum of 1..N one term per clock. It holds the result under a valid/ack handshake, supports back-to-back operands, and flags overflow with saturation. An optional sum-of-squares mode is available. Sits between an operand producer and a result consumer in the experiment datapath.

---
 rtl/sum_n_param.sv | 173 +++++++++++++++++
 tb/tb_sum_n_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_n_param.sv
// sum_n_param: iterative series accumulator.
// Captures operand N through a valid/ready handshake. It then adds one term per
// clock: k in mode 0, or k*k in mode 1. The result is held under a valid/ack
// handshake. Overflow saturates the result to all-ones and sets a sticky flag.
//
// Optional feature macro: SUM_N_SQUARES_EN. When it is defined, the mode input
// is honoured and a multiplier forms k*k. When it is undefined, mode is ignored
// and the block always sums k.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   N            operand (unsigned, N_WIDTH bits)
//   N_valid_in   operand valid
//   N_ready      combinational: operand accepted this cycle when valid
//   mode         0 = sum of k, 1 = sum of k*k (sampled with N)
//   sum_ack      consumer acknowledges the result (DONE only)
//   sum_out      result register (SUM_WIDTH bits)
//   sum_valid    sum_out holds a completed result
//   sum_overflow the current result saturated
module sum_n_param #(
    parameter int unsigned N_WIDTH   = 3,
    parameter int unsigned SUM_WIDTH = 2 * N_WIDTH - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_WIDTH-1:0]   N,
    input  logic                 N_valid_in,
    output logic                 N_ready,
    input  logic                 mode,
    input  logic                 sum_ack,
    output logic [SUM_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    output logic                 sum_overflow
);

    localparam int unsigned TERM_W = 2 * N_WIDTH;
    // Width of the add, large enough that neither carry-out nor an oversized term is lost.
    localparam int unsigned EXT_W  = ((TERM_W > SUM_WIDTH) ? TERM_W : SUM_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                 state_q,   state_d;
    logic [N_WIDTH-1:0]     count_q,   count_d;
    logic [SUM_WIDTH-1:0]   acc_q,     acc_d;
    logic                   ovf_q,     ovf_d;
    logic [SUM_WIDTH-1:0]   sum_out_q, sum_out_d;
    logic                   valid_q,   valid_d;
    logic                   sum_ovf_q, sum_ovf_d;
    logic                   mode_q;

    logic                   capture_c;
    logic [TERM_W-1:0]      lin_term_c;
    logic [TERM_W-1:0]      sq_term_c;
    logic [TERM_W-1:0]      term_c;
    logic [EXT_W-1:0]       sum_ext_c;
    logic                   add_ovf_c;
    logic [SUM_WIDTH-1:0]   acc_next_c;
    logic                   ovf_next_c;

    assign lin_term_c = TERM_W'(count_q);

`ifdef SUM_N_SQUARES_EN
    logic mode_d;

    assign sq_term_c = TERM_W'(count_q) * TERM_W'(count_q);
    assign mode_d    = capture_c ? mode : mode_q;

    // Mode is latched with the operand and held for the whole accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic unused_mode;

    // Without the squares feature there is no multiplier and the mode is fixed at 0.
    assign unused_mode = mode;
    assign sq_term_c   = lin_term_c;
    assign mode_q      = 1'b0;
`endif

    assign term_c = mode_q ? sq_term_c : lin_term_c;

    // Any bit at or above SUM_WIDTH means the result no longer fits. This covers
    // both carry-out and a single term of 2^SUM_WIDTH or more.
    assign sum_ext_c  = EXT_W'(acc_q) + EXT_W'(term_c);
    assign add_ovf_c  = |sum_ext_c[EXT_W-1:SUM_WIDTH];
    assign ovf_next_c = ovf_q | add_ovf_c;
    assign acc_next_c = ovf_next_c ? {SUM_WIDTH{1'b1}} : sum_ext_c[SUM_WIDTH-1:0];

    assign N_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & sum_ack);
    assign capture_c = N_valid_in & N_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        sum_out_d = sum_out_q;
        valid_d   = valid_q;
        sum_ovf_d = sum_ovf_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_ACCUM: begin
                acc_d   = acc_next_c;
                ovf_d   = ovf_next_c;
                count_d = count_q - N_WIDTH'(1);
                // count of 0 or 1 means this is the final term.
                if (count_q <= N_WIDTH'(1)) begin
                    state_d   = S_DONE;
                    sum_out_d = acc_next_c;
                    sum_ovf_d = ovf_next_c;
                    valid_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (sum_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A capture is only possible in IDLE, or in DONE with ack, so it cannot collide with ACCUM.
        if (capture_c) begin
            state_d = S_ACCUM;
            count_d = N;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sum_out_q <= '0;
            valid_q   <= 1'b0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sum_out_q <= sum_out_d;
            valid_q   <= valid_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

    assign sum_out      = sum_out_q;
    assign sum_valid    = valid_q;
    assign sum_overflow = sum_ovf_q;

endmodule

// File: tb/tb_sum_n_param.sv
// Bench for sum_n_param. Three instances share the same stimulus:
// default widths (SUM_WIDTH=5), SUM_WIDTH=4 to exercise saturation,
// and SUM_WIDTH=9 for exact squares results.
module tb_sum_n_param;

`ifdef SUM_N_SQUARES_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] N;
    logic       N_valid_in;
    logic       mode;
    logic       sum_ack;

    logic       rdy [3];
    logic       sv  [3];
    logic       sov [3];
    logic [4:0] so5;
    logic [3:0] so4;
    logic [8:0] so9;

    int total = 0;
    int bad   = 0;
    int exp_s [3];
    int exp_o [3];

    sum_n_param #(.N_WIDTH(3)) u_def (
        .clk(clk), .reset(reset), .N(N), .N_valid_in(N_valid_in), .N_ready(rdy[0]),
        .mode(mode), .sum_ack(sum_ack), .sum_out(so5), .sum_valid(sv[0]), .sum_overflow(sov[0])
    );

    sum_n_param #(.N_WIDTH(3), .SUM_WIDTH(4)) u_ovf (
        .clk(clk), .reset(reset), .N(N), .N_valid_in(N_valid_in), .N_ready(rdy[1]),
        .mode(mode), .sum_ack(sum_ack), .sum_out(so4), .sum_valid(sv[1]), .sum_overflow(sov[1])
    );

    sum_n_param #(.N_WIDTH(3), .SUM_WIDTH(9)) u_sq (
        .clk(clk), .reset(reset), .N(N), .N_valid_in(N_valid_in), .N_ready(rdy[2]),
        .mode(mode), .sum_ack(sum_ack), .sum_out(so9), .sum_valid(sv[2]), .sum_overflow(sov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int so_of(input int i);
        case (i)
            0:       return int'(so5);
            1:       return int'(so4);
            default: return int'(so9);
        endcase
    endfunction

    function automatic int sw_of(input int i);
        case (i)
            0:       return 5;
            1:       return 4;
            default: return 9;
        endcase
    endfunction

    // Closed-form reference: the partial sums only grow, so saturation happens iff the exact total exceeds the maximum.
    function automatic void model(input int n, input bit md, input int sw, output int s, output int ov);
        longint t;
        longint mx;
        if (md && SQ_EN) t = longint'(n) * (n + 1) * (2 * n + 1) / 6;
        else             t = longint'(n) * (n + 1) / 2;
        mx = (longint'(1) << sw) - 1;
        if (t > mx) begin s = int'(mx); ov = 1; end
        else        begin s = int'(t);  ov = 0; end
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Present an operand on the current negedge; it is captured on the next posedge.
    task automatic start_op(input int n, input bit md, input bit with_ack);
        N          = 3'(n);
        mode       = md;
        N_valid_in = 1'b1;
        sum_ack    = with_ack;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("ready_at_capture[%0d]", i), int'(rdy[i]), 1);
        @(negedge clk);
        N_valid_in = 1'b0;
        sum_ack    = 1'b0;
        N          = 3'($urandom);
        mode       = 1'($urandom);
        if (with_ack)
            for (int i = 0; i < 3; i++) chk($sformatf("valid_fell_b2b[%0d]", i), int'(sv[i]), 0);
    endtask

    // Wait for the result, checking latency, ready-low during ACCUM, and the result values.
    task automatic finish_op(input int n, input int e0, input int o0, input int e1, input int o1,
                             input int e2, input int o2);
        int edges;
        edges = 0;
        while (!sv[0] && edges < 40) begin
            chk("ready_low_accum", int'(rdy[0]), 0);
            @(negedge clk);
            edges++;
        end
        chk("latency", edges, (n < 1) ? 1 : n);
        exp_s[0] = e0; exp_o[0] = o0;
        exp_s[1] = e1; exp_o[1] = o1;
        exp_s[2] = e2; exp_o[2] = o2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sum_valid[%0d] n=%0d", i, n), int'(sv[i]), 1);
            chk($sformatf("sum_out[%0d] n=%0d", i, n), so_of(i), exp_s[i]);
            chk($sformatf("sum_overflow[%0d] n=%0d", i, n), int'(sov[i]), exp_o[i]);
        end
    endtask

    task automatic finish_model(input int n, input bit md);
        int s[3];
        int o[3];
        for (int i = 0; i < 3; i++) model(n, md, sw_of(i), s[i], o[i]);
        finish_op(n, s[0], o[0], s[1], o[1], s[2], o[2]);
    endtask

    // Hold the result for a few cycles without ack, then ack it and check the outputs are kept.
    task automatic ack_op(input int hold);
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("ready_done_noack", int'(rdy[0]), 0);
            @(negedge clk);
            chk("held_valid", int'(sv[0]), 1);
            chk("held_sum", so_of(0), exp_s[0]);
        end
        sum_ack = 1'b1;
        #1;
        chk("ready_done_ack", int'(rdy[0]), 1);
        @(negedge clk);
        sum_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid_after_ack[%0d]", i), int'(sv[i]), 0);
            chk($sformatf("sum_kept_after_ack[%0d]", i), so_of(i), exp_s[i]);
            chk($sformatf("ovf_kept_after_ack[%0d]", i), int'(sov[i]), exp_o[i]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_sum_out[%0d]", tag, i), so_of(i), 0);
            chk($sformatf("%s_sum_valid[%0d]", tag, i), int'(sv[i]), 0);
            chk($sformatf("%s_sum_overflow[%0d]", tag, i), int'(sov[i]), 0);
            chk($sformatf("%s_ready[%0d]", tag, i), int'(rdy[i]), 1);
        end
    endtask

    typedef struct {
        int n;
        int e5;
        int e4;
        int o4;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit in_done;

        // Mode-0 vectors; the SUM_WIDTH=4 column saturates above 15.
        vecs[0] = '{n: 7, e5: 28, e4: 15, o4: 1};
        vecs[1] = '{n: 4, e5: 10, e4: 10, o4: 0};
        vecs[2] = '{n: 0, e5: 0,  e4: 0,  o4: 0};
        vecs[3] = '{n: 1, e5: 1,  e4: 1,  o4: 0};
        vecs[4] = '{n: 3, e5: 6,  e4: 6,  o4: 0};
        vecs[5] = '{n: 6, e5: 21, e4: 15, o4: 1};
        vecs[6] = '{n: 5, e5: 15, e4: 15, o4: 0};
        vecs[7] = '{n: 2, e5: 3,  e4: 3,  o4: 0};

        reset      = 1'b0;
        N          = '0;
        N_valid_in = 1'b0;
        mode       = 1'b0;
        sum_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            start_op(vecs[v].n, 1'b0, 1'b0);
            finish_op(vecs[v].n, vecs[v].e5, 0, vecs[v].e4, vecs[v].o4, vecs[v].e5, 0);
            ack_op(v % 3);
        end

        // Back-to-back: ack and the new operand arrive on the same edge.
        start_op(7, 1'b0, 1'b0);
        finish_op(7, 28, 0, 15, 1, 28, 0);
        start_op(3, 1'b0, 1'b1);
        finish_op(3, 6, 0, 6, 0, 6, 0);
        ack_op(0);

        // Squares mode.
        start_op(3, 1'b1, 1'b0);
        if (SQ_EN) finish_op(3, 14, 0, 14, 0, 14, 0);
        else       finish_op(3, 6, 0, 6, 0, 6, 0);
        ack_op(1);
        start_op(7, 1'b1, 1'b0);
        if (SQ_EN) finish_op(7, 31, 1, 15, 1, 140, 0);
        else       finish_op(7, 28, 0, 15, 1, 28, 0);
        ack_op(0);

        // Reset in the middle of an accumulation.
        start_op(7, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_op(2, 1'b0, 1'b0);
        finish_op(2, 3, 0, 3, 0, 3, 0);
        ack_op(0);

        // Ack held high continuously: the result is valid for exactly one cycle.
        start_op(5, 1'b0, 1'b0);
        sum_ack = 1'b1;
        finish_op(5, 15, 0, 15, 0, 15, 0);
        @(negedge clk);
        chk("ack_held_one_cycle", int'(sv[0]), 0);
        sum_ack = 1'b0;

        // Random operands, modes, gaps and back-to-back traffic against the model.
        in_done = 1'b0;
        for (int r = 0; r < 40; r++) begin
            int n;
            bit md;
            bit b2b;
            n   = int'($urandom_range(0, 7));
            md  = 1'($urandom);
            b2b = 1'($urandom);
            if (in_done && b2b) begin
                start_op(n, md, 1'b1);
            end else begin
                if (in_done) ack_op(int'($urandom_range(0, 2)));
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
                start_op(n, md, 1'b0);
            end
            finish_model(n, md);
            in_done = 1'b1;
        end
        ack_op(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
